// File: rtl/demux_1in5_if.sv
// demux_1in5_if
// Bundles the producer-side word stream and the five consumer-side channels
// of the 1-to-5 demultiplexer so the block can be wired with one port.
// The slave modport is the demux itself, the master modport is whoever
// drives the producer inputs and the consumer ready lines.
interface demux_1in5_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
);

    logic [WIDTH-1:0] i_dat;
    logic [2:0]       i_sel;
    logic             i_vld;
    logic             o_rdy;
    logic [WIDTH-1:0] o_dat0;
    logic [WIDTH-1:0] o_dat1;
    logic [WIDTH-1:0] o_dat2;
    logic [WIDTH-1:0] o_dat3;
    logic [WIDTH-1:0] o_dat4;
    logic [4:0]       o_vld;
    logic [4:0]       i_rdy;
    logic             o_err;
    logic [CNTW-1:0]  o_drop_cnt;

    modport slave (
        input  i_dat, i_sel, i_vld, i_rdy,
        output o_rdy, o_dat0, o_dat1, o_dat2, o_dat3, o_dat4,
               o_vld, o_err, o_drop_cnt
    );

    modport master (
        output i_dat, i_sel, i_vld, i_rdy,
        input  o_rdy, o_dat0, o_dat1, o_dat2, o_dat3, o_dat4,
               o_vld, o_err, o_drop_cnt
    );

endinterface

// File: rtl/demux_1in5.sv
// demux_1in5
// Registered 1-to-5 demultiplexer. Each input word is steered by its select
// field into a one-entry holding register on one of five channels; every
// channel has its own valid/ready handshake so a stalled consumer only
// blocks words headed for that channel. Words whose select is 5..7 are
// always consumed, dropped, flagged with a one-cycle error pulse and
// counted in a saturating counter.
module demux_1in5 #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    demux_1in5_if.slave   bus
);

    logic [WIDTH-1:0] dat_q [5];
    logic [WIDTH-1:0] dat_d [5];
    logic [4:0]       vld_q;
    logic [4:0]       vld_d;
    logic             err_q;
    logic             err_d;
    logic [CNTW-1:0]  dropCnt_q;
    logic [CNTW-1:0]  dropCnt_d;

    logic [4:0]       chanFree;
    logic [7:0]       freeBySel;
    logic             selValid;
    logic             inRdy;
    logic             accept;
    logic             loadValid;
    logic             dropEvent;
    logic [4:0]       loadVec;

    // Readiness toward the producer: a channel can take a word when it is
    // empty or its consumer is draining it this cycle. Selects 5..7 map to
    // constant ones so invalid words are never stalled; i_vld is not used.
    always_comb begin
        chanFree  = ~vld_q | bus.i_rdy;
        freeBySel = {3'b111, chanFree};
        selValid  = (bus.i_sel <= 3'd4);
        inRdy     = freeBySel[bus.i_sel];
        accept    = bus.i_vld & inRdy;
        loadValid = accept & selValid;
        dropEvent = accept & ~selValid;
    end

    // Next-state for the five holding registers: a load wins over a drain,
    // which keeps a channel at one word per cycle with an always-ready
    // consumer; a drain alone clears valid but leaves the data untouched.
    always_comb begin
        loadVec = '0;
        vld_d   = vld_q;
        for (int k = 0; k < 5; k++) begin
            loadVec[k] = loadValid && (bus.i_sel == 3'(k));
            vld_d[k]   = loadVec[k] | (vld_q[k] & ~bus.i_rdy[k]);
            dat_d[k]   = loadVec[k] ? bus.i_dat : dat_q[k];
        end
    end

    // Next-state for the drop bookkeeping: the error pulse lasts exactly
    // the cycle after each dropped word and the counter sticks at all-ones.
    always_comb begin
        err_d     = dropEvent;
        dropCnt_d = dropCnt_q;
        if (dropEvent && (dropCnt_q != '1)) begin
            dropCnt_d = dropCnt_q + CNTW'(1);
        end
    end

    // State registers; reset discards any held words and clears the counter,
    // and words presented during reset are ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 5; k++) begin
                dat_q[k] <= '0;
            end
            vld_q     <= '0;
            err_q     <= 1'b0;
            dropCnt_q <= '0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                dat_q[k] <= dat_d[k];
            end
            vld_q     <= vld_d;
            err_q     <= err_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    assign bus.o_rdy      = inRdy;
    assign bus.o_dat0     = dat_q[0];
    assign bus.o_dat1     = dat_q[1];
    assign bus.o_dat2     = dat_q[2];
    assign bus.o_dat3     = dat_q[3];
    assign bus.o_dat4     = dat_q[4];
    assign bus.o_vld      = vld_q;
    assign bus.o_err      = err_q;
    assign bus.o_drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_demux_1in5.sv
// tb_demux_1in5
// Drives the demux with directed scenarios and random traffic and compares
// every cycle against a channel-queue reference model. A second instance
// with a 2-bit counter exercises counter saturation.
module tb_demux_1in5;

    logic clk;
    logic rst;

    demux_1in5_if #(.WIDTH(8), .CNTW(8)) bus  ();
    demux_1in5_if #(.WIDTH(8), .CNTW(2)) busS ();

    demux_1in5 #(.WIDTH(8), .CNTW(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    demux_1in5 #(.WIDTH(8), .CNTW(2)) dutSat (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (busS.slave)
    );

    logic [7:0] obsDat [5];
    assign obsDat[0] = bus.o_dat0;
    assign obsDat[1] = bus.o_dat1;
    assign obsDat[2] = bus.o_dat2;
    assign obsDat[3] = bus.o_dat3;
    assign obsDat[4] = bus.o_dat4;

    // Reference model: each channel is a queue of at most one pending word,
    // plus the last word written to it, the error flag and the drop count.
    logic [7:0] holdQ [5][$];
    logic [7:0] lastDat [5];
    logic       expErr;
    int         expCnt;
    logic       lastAcc;

    int nChecks;
    int nFails;

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 5; k++) begin
            holdQ[k].delete();
            lastDat[k] = 8'h00;
        end
        expErr = 1'b0;
        expCnt = 0;
    endtask

    // One clock cycle: drive inputs, compare all outputs at the falling edge
    // against the model, advance the model, then cross the rising edge.
    task automatic applyStimulus(input logic [7:0] dat, input logic [2:0] sel,
                                 input logic vld, input logic [4:0] rdy, input logic rstIn);
        logic       expRdy;
        logic [4:0] expVld;
        logic [7:0] w;
        bus.i_dat = dat;
        bus.i_sel = sel;
        bus.i_vld = vld;
        bus.i_rdy = rdy;
        rst       = rstIn;
        @(negedge clk);
        for (int k = 0; k < 5; k++) expVld[k] = (holdQ[k].size() != 0);
        if (sel >= 3'd5) expRdy = 1'b1;
        else expRdy = (holdQ[sel].size() == 0) || rdy[sel];
        checkOutput("o_rdy", 32'(bus.o_rdy), 32'(expRdy));
        checkOutput("o_vld", 32'(bus.o_vld), 32'(expVld));
        checkOutput("o_err", 32'(bus.o_err), 32'(expErr));
        checkOutput("o_drop_cnt", 32'(bus.o_drop_cnt), expCnt);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("o_dat%0d", k), 32'(obsDat[k]), 32'(lastDat[k]));
        end
        lastAcc = 1'b0;
        if (rstIn) begin
            modelReset();
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (holdQ[k].size() != 0 && rdy[k]) begin
                    w = holdQ[k].pop_front();
                    checkOutput($sformatf("deliver%0d", k), 32'(obsDat[k]), 32'(w));
                end
            end
            lastAcc = vld && expRdy;
            expErr  = lastAcc && (sel >= 3'd5);
            if (expErr && expCnt < 255) expCnt++;
            if (lastAcc && sel < 3'd5) begin
                holdQ[sel].push_back(dat);
                lastDat[sel] = dat;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         words;
        int         cycles;
        logic [7:0] d;
        logic [2:0] s;
        logic       v;
        logic [4:0] r;
        logic       holdReq;
        int         satExp [5];

        nChecks = 0;
        nFails  = 0;
        lastAcc = 1'b0;
        modelReset();
        satExp = '{1, 2, 3, 3, 3};

        rst       = 1'b1;
        bus.i_dat = 8'h00;
        bus.i_sel = 3'd0;
        bus.i_vld = 1'b0;
        bus.i_rdy = 5'b00000;
        busS.i_dat = 8'h00;
        busS.i_sel = 3'd0;
        busS.i_vld = 1'b0;
        busS.i_rdy = 5'b11111;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state and words ignored during reset");
        applyStimulus(8'hEE, 3'd0, 1'b1, 5'b00000, 1'b1);
        applyStimulus(8'h00, 3'd0, 1'b0, 5'b00000, 1'b0);

        $display("[TB] routing");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'hA0 + 8'(k), 3'(k), 1'b1, 5'b11111, 1'b0);
        end
        applyStimulus(8'h00, 3'd6, 1'b0, 5'b11111, 1'b0);
        applyStimulus(8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(8'h11, 3'd2, 1'b1, 5'b11011, 1'b0);
        checkOutput("bp_hold_dat", 32'(bus.o_dat2), 32'h11);
        applyStimulus(8'h22, 3'd2, 1'b1, 5'b11011, 1'b0);
        checkOutput("bp_stalled_dat", 32'(bus.o_dat2), 32'h11);
        applyStimulus(8'h22, 3'd2, 1'b1, 5'b11111, 1'b0);
        checkOutput("bp_reload_dat", 32'(bus.o_dat2), 32'h22);
        checkOutput("bp_reload_vld", 32'(bus.o_vld[2]), 32'h1);
        applyStimulus(8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);

        $display("[TB] channel independence");
        applyStimulus(8'h0C, 3'd0, 1'b1, 5'b11110, 1'b0);
        applyStimulus(8'h33, 3'd3, 1'b1, 5'b11110, 1'b0);
        applyStimulus(8'h34, 3'd3, 1'b1, 5'b11110, 1'b0);
        checkOutput("indep_dat3", 32'(bus.o_dat3), 32'h34);
        applyStimulus(8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);
        applyStimulus(8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);

        $display("[TB] invalid selects");
        for (int k = 5; k < 8; k++) begin
            applyStimulus(8'h77, 3'(k), 1'b1, 5'b11111, 1'b0);
            checkOutput("inv_err", 32'(bus.o_err), 32'h1);
        end
        checkOutput("inv_cnt", 32'(bus.o_drop_cnt), 32'd3);
        applyStimulus(8'h00, 3'd7, 1'b0, 5'b11111, 1'b0);
        checkOutput("inv_err_clear", 32'(bus.o_err), 32'h0);

        $display("[TB] reset mid-operation");
        applyStimulus(8'h41, 3'd1, 1'b1, 5'b00000, 1'b0);
        applyStimulus(8'h44, 3'd4, 1'b1, 5'b00000, 1'b0);
        applyStimulus(8'h99, 3'd2, 1'b1, 5'b00000, 1'b1);
        checkOutput("rst_vld", 32'(bus.o_vld), 32'h0);
        checkOutput("rst_cnt", 32'(bus.o_drop_cnt), 32'h0);
        applyStimulus(8'h5A, 3'd1, 1'b1, 5'b00000, 1'b0);
        checkOutput("post_rst_dat1", 32'(bus.o_dat1), 32'h5A);
        applyStimulus(8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);

        $display("[TB] randomized traffic");
        words   = 0;
        cycles  = 0;
        holdReq = 1'b0;
        d = 8'h00;
        s = 3'd0;
        v = 1'b0;
        while (words < 80 && cycles < 2000) begin
            if (!holdReq) begin
                d = 8'($urandom);
                s = 3'($urandom_range(0, 7));
                v = ($urandom_range(0, 3) != 0);
            end
            r = 5'($urandom);
            applyStimulus(d, s, v, r, 1'b0);
            if (lastAcc) words++;
            holdReq = v && !lastAcc;
            cycles++;
        end
        checkOutput("rand_words", words, 80);
        applyStimulus(8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);
        applyStimulus(8'h00, 3'd0, 1'b0, 5'b11111, 1'b0);
        checkOutput("rand_drained", 32'(bus.o_vld), 32'h0);

        $display("[TB] counter saturation");
        bus.i_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            busS.i_sel = 3'(5 + (i % 3));
            busS.i_vld = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("sat_cnt%0d", i), 32'(busS.o_drop_cnt), satExp[i]);
            checkOutput($sformatf("sat_err%0d", i), 32'(busS.o_err), 32'h1);
        end
        busS.i_vld = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
